// File: rtl/rx_scramble_pkg.sv
// Shared scrambler definitions for the PCIe Gen1/2 RX descrambler and the
// TX scrambler.
//
// Contents:
//   SEED_DEFAULT, COM_SYM_DEFAULT, SKP_SYM_DEFAULT  default parameter values
//   LFSR_TAPS     Galois feedback taps (bits 3,4,5; bit 0 takes the MSB)
//   lfsr_step(s)  one serial shift of G(X)=X^16+X^5+X^4+X^3+1
//   lfsr_adv8(s)  eight serial shifts (one symbol's worth)
//   lfsr_key(s)   8-bit scrambling key; bit j is s[15] after j shifts
package rx_scramble_pkg;

  localparam logic [15:0] SEED_DEFAULT    = 16'hFFFF;
  localparam logic [7:0]  COM_SYM_DEFAULT = 8'hBC;
  localparam logic [7:0]  SKP_SYM_DEFAULT = 8'h1C;
  localparam logic [15:0] LFSR_TAPS       = 16'h0038;

  // The MSB rotates into bit 0 and is also folded into the tap positions.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[15];
    lfsr_step = {s[14:0], fb} ^ (fb ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int j = 0; j < 8; j++) begin
      t = lfsr_step(t);
    end
    lfsr_adv8 = t;
  endfunction

  function automatic logic [7:0] lfsr_key(input logic [15:0] s);
    logic [15:0] t;
    logic [7:0]  k;
    t = s;
    k = 8'h00;
    for (int j = 0; j < 8; j++) begin
      k[j] = t[15];
      t    = lfsr_step(t);
    end
    lfsr_key = k;
  endfunction

endpackage

// File: rtl/rx_descr_lane.sv
// One symbol stage of the descrambler chain.
//
// Ports:
//   s_in      LFSR state presented to this symbol
//   data      received symbol
//   k         symbol is a K code
//   valid     symbol is valid and on an active lane
//   s_out     LFSR state handed to the next symbol
//   data_out  descrambled symbol (K codes pass through, invalid gives 0)
module rx_descr_lane
  import rx_scramble_pkg::*;
#(
  parameter logic [15:0] SEED    = SEED_DEFAULT,
  parameter logic [7:0]  COM_SYM = COM_SYM_DEFAULT,
  parameter logic [7:0]  SKP_SYM = SKP_SYM_DEFAULT
) (
  input  logic [15:0] s_in,
  input  logic [7:0]  data,
  input  logic        k,
  input  logic        valid,
  output logic [15:0] s_out,
  output logic [7:0]  data_out
);

  // COM reseeds, SKP freezes the LFSR so the TX side stays aligned after
  // elastic-buffer SKP insertion/removal; every other symbol costs 8 shifts.
  always_comb begin
    s_out    = s_in;
    data_out = 8'h00;
    if (valid) begin
      if (k) begin
        data_out = data;
        if (data == COM_SYM) begin
          s_out = SEED;
        end else if (data != SKP_SYM) begin
          s_out = lfsr_adv8(s_in);
        end
      end else begin
        data_out = data ^ lfsr_key(s_in);
        s_out    = lfsr_adv8(s_in);
      end
    end
  end

endmodule

// File: rtl/rx_descrambler.sv
// PCIe Gen1/2 receive descrambler, 1/2/4 symbols per pclk.
//
// Ports:
//   pclk, reset          PIPE clock, synchronous active-high reset
//   turnOff              bypass descrambling; LFSR keeps tracking
//   PIPEWIDTH            8/16/32 selects 1/2/4 active lanes, else none
//   rxData/K/Valid       decoded symbols, lane 0 first in time
//   descrDataOut         descrambled symbols (1 pclk latency)
//   descrDataK           registered rxDataK
//   descrDataValid       registered valid, masked to active lanes
//   locked               only with RX_DESCRAMBLER_LOCK_EN: a COM has been seen
//
// Build option RX_DESCRAMBLER_LOCK_EN: suppress valid until the first COM.
module rx_descrambler
  import rx_scramble_pkg::*;
#(
  parameter logic [15:0] SEED    = SEED_DEFAULT,
  parameter logic [7:0]  COM_SYM = COM_SYM_DEFAULT,
  parameter logic [7:0]  SKP_SYM = SKP_SYM_DEFAULT
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        turnOff,
  input  logic [5:0]  PIPEWIDTH,
  input  logic [31:0] rxData,
  input  logic [3:0]  rxDataK,
  input  logic [3:0]  rxDataValid,
  output logic [31:0] descrDataOut,
  output logic [3:0]  descrDataK,
  output logic [3:0]  descrDataValid
`ifdef RX_DESCRAMBLER_LOCK_EN
  ,
  output logic        locked
`endif
);

  logic [15:0]      lfsr;
  logic [3:0]       active;
  logic [3:0]       lane_valid;
  logic [4:0][15:0] s_chain;
  logic [3:0][7:0]  lane_out;
  logic [31:0]      data_next;
  logic [3:0]       valid_next;

  always_comb begin
    active = 4'b0000;
    case (PIPEWIDTH)
      6'd8:    active = 4'b0001;
      6'd16:   active = 4'b0011;
      6'd32:   active = 4'b1111;
      default: active = 4'b0000;
    endcase
  end

  // Inactive lanes look invalid to the chain, so they leave the LFSR alone.
  assign lane_valid = rxDataValid & active;
  assign s_chain[0] = lfsr;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    rx_descr_lane #(
      .SEED    (SEED),
      .COM_SYM (COM_SYM),
      .SKP_SYM (SKP_SYM)
    ) u_lane (
      .s_in     (s_chain[i]),
      .data     (rxData[i*8 +: 8]),
      .k        (rxDataK[i]),
      .valid    (lane_valid[i]),
      .s_out    (s_chain[i+1]),
      .data_out (lane_out[i])
    );
  end

  always_comb begin
    data_next = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (active[i]) begin
        data_next[i*8 +: 8] = turnOff ? rxData[i*8 +: 8] : lane_out[i];
      end
    end
  end

`ifdef RX_DESCRAMBLER_LOCK_EN
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0] lock_state;
  logic [4:0] seen;

  // seen[i] says a COM occurred before lane i (this cycle or earlier), so
  // the COM lane itself and everything after it are released.
  always_comb begin
    seen       = 5'b0;
    valid_next = 4'b0;
    seen[0]    = (lock_state == ST_LOCKED);
    for (int i = 0; i < 4; i++) begin
      if (lane_valid[i] && rxDataK[i] && (rxData[i*8 +: 8] == COM_SYM)) begin
        seen[i+1]     = 1'b1;
        valid_next[i] = 1'b1;
      end else begin
        seen[i+1]     = seen[i];
        valid_next[i] = lane_valid[i] & seen[i];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      lock_state <= ST_UNLOCKED;
    end else if (seen[4]) begin
      lock_state <= ST_LOCKED;
    end
  end

  assign locked = (lock_state == ST_LOCKED);
`else
  assign valid_next = lane_valid;
`endif

  always_ff @(posedge pclk) begin
    if (reset) begin
      lfsr           <= SEED;
      descrDataOut   <= 32'h0;
      descrDataK     <= 4'h0;
      descrDataValid <= 4'h0;
    end else begin
      lfsr           <= s_chain[4];
      descrDataOut   <= data_next;
      descrDataK     <= rxDataK;
      descrDataValid <= valid_next;
    end
  end

endmodule

// File: tb/tb_rx_descrambler.sv
// Self-checking bench for rx_descrambler. A bit-serial reference model
// predicts each output word when stimulus is driven and queues it; the
// word is popped and compared one pclk later. Known PCIe scrambler key
// bytes are also checked as fixed constants.
module tb_rx_descrambler;

  logic        pclk = 1'b0;
  logic        reset;
  logic        turnOff;
  logic [5:0]  PIPEWIDTH;
  logic [31:0] rxData;
  logic [3:0]  rxDataK;
  logic [3:0]  rxDataValid;
  logic [31:0] descrDataOut;
  logic [3:0]  descrDataK;
  logic [3:0]  descrDataValid;
`ifdef RX_DESCRAMBLER_LOCK_EN
  logic        locked;
`endif

  always #5 pclk = ~pclk;

  rx_descrambler dut (
    .pclk           (pclk),
    .reset          (reset),
    .turnOff        (turnOff),
    .PIPEWIDTH      (PIPEWIDTH),
    .rxData         (rxData),
    .rxDataK        (rxDataK),
    .rxDataValid    (rxDataValid),
    .descrDataOut   (descrDataOut),
    .descrDataK     (descrDataK),
    .descrDataValid (descrDataValid)
`ifdef RX_DESCRAMBLER_LOCK_EN
    ,
    .locked         (locked)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  k;
    logic [3:0]  valid;
    logic        locked;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_lfsr;
  logic        m_locked;

  // Reference LFSR: shift left, XOR polynomial 0x0039 when the MSB falls out.
  function automatic logic [15:0] m_shift(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
  endfunction

  function automatic logic [15:0] m_adv8(input logic [15:0] s);
    logic [15:0] t = s;
    for (int j = 0; j < 8; j++) t = m_shift(t);
    return t;
  endfunction

  function automatic logic [7:0] m_key(input logic [15:0] s);
    logic [15:0] t = s;
    logic [7:0]  r = 8'h00;
    for (int j = 0; j < 8; j++) begin
      r[j] = t[15];
      t    = m_shift(t);
    end
    return r;
  endfunction

  // Drive one cycle, predict its output word, queue it, then step one pclk.
  task automatic applyStimulus(input logic rst, input logic off, input logic [5:0] w,
                               input logic [31:0] d, input logic [3:0] k, input logic [3:0] v);
    exp_t        e;
    logic [15:0] s;
    logic        seen;
    logic [7:0]  b;
    logic [7:0]  o;
    int          nact;
    reset       = rst;
    turnOff     = off;
    PIPEWIDTH   = w;
    rxData      = d;
    rxDataK     = k;
    rxDataValid = v;
    e = '0;
    if (rst) begin
      m_lfsr   = 16'hFFFF;
      m_locked = 1'b0;
    end else begin
      nact = (w == 6'd8) ? 1 : (w == 6'd16) ? 2 : (w == 6'd32) ? 4 : 0;
      s    = m_lfsr;
      seen = m_locked;
      e.k  = k;
      for (int i = 0; i < 4; i++) begin
        if (i < nact) begin
          b = d[i*8 +: 8];
          o = 8'h00;
          if (v[i]) begin
            if (k[i]) begin
              o = b;
              if (b == 8'hBC) begin
                s    = 16'hFFFF;
                seen = 1'b1;
              end else if (b != 8'h1C) begin
                s = m_adv8(s);
              end
            end else begin
              o = b ^ m_key(s);
              s = m_adv8(s);
            end
`ifdef RX_DESCRAMBLER_LOCK_EN
            e.valid[i] = seen;
`else
            e.valid[i] = 1'b1;
`endif
          end
          if (off) o = b;
          e.data[i*8 +: 8] = o;
        end
      end
      m_lfsr   = s;
      m_locked = seen;
    end
    e.locked = m_locked;
    sb_q.push_back(e);
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 6'd8, 32'hDEADBEEF, 4'hF, 4'hF);
      e = sb_q.pop_front();
      total++;
      if ({descrDataOut, descrDataK, descrDataValid} !== {e.data, e.k, e.valid}) begin
        bad++;
        $display("[TB] FAIL reset got=%h/%h/%h want=%h/%h/%h", descrDataOut, descrDataK, descrDataValid, e.data, e.k, e.valid);
      end
    end
    total++;
    if (descrDataOut !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_zero got=%h want=00000000", descrDataOut);
    end
  endtask

`ifdef RX_DESCRAMBLER_LOCK_EN
  task automatic test_lock();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 6'd16, (i == 2) ? 32'h0000_BC00 : 32'h0000_1234, (i == 2) ? 4'b0010 : 4'b0000, 4'b0011);
      e = sb_q.pop_front();
      total++;
      if ({descrDataOut, descrDataK, descrDataValid, locked} !== {e.data, e.k, e.valid, e.locked}) begin
        bad++;
        $display("[TB] FAIL lock got=%h/%h/%h/%b want=%h/%h/%h/%b", descrDataOut, descrDataK, descrDataValid, locked, e.data, e.k, e.valid, e.locked);
      end
      total++;
      if ({locked, descrDataValid} !== ((i == 2) ? 5'b1_0010 : 5'b0_0000)) begin
        bad++;
        $display("[TB] FAIL lock_const got=%b/%b cycle=%0d", locked, descrDataValid, i);
      end
    end
  endtask
`endif

  task automatic test_single_lane();
    logic [7:0] syms[5]  = '{8'hBC, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] known[5] = '{8'hBC, 8'hFF, 8'h17, 8'hC0, 8'h14};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 6'd8, {24'h0, syms[i]}, (i == 0) ? 4'b0001 : 4'b0000, 4'b0001);
      e = sb_q.pop_front();
      total++;
      if ({descrDataOut, descrDataK, descrDataValid} !== {e.data, e.k, e.valid}) begin
        bad++;
        $display("[TB] FAIL x1 got=%h/%h/%h want=%h/%h/%h", descrDataOut, descrDataK, descrDataValid, e.data, e.k, e.valid);
      end
      total++;
      if (descrDataOut[7:0] !== known[i]) begin
        bad++;
        $display("[TB] FAIL x1_key got=%h want=%h", descrDataOut[7:0], known[i]);
      end
    end
  endtask

  task automatic test_quad_lane();
    logic [31:0] known[2] = '{32'hC017FFBC, 32'h02E7B214};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 6'd32, (i == 0) ? 32'h0000_00BC : 32'h0, (i == 0) ? 4'b0001 : 4'b0000, 4'hF);
      e = sb_q.pop_front();
      total++;
      if ({descrDataOut, descrDataK, descrDataValid} !== {e.data, e.k, e.valid}) begin
        bad++;
        $display("[TB] FAIL x4 got=%h/%h/%h want=%h/%h/%h", descrDataOut, descrDataK, descrDataValid, e.data, e.k, e.valid);
      end
      total++;
      if (descrDataOut !== known[i]) begin
        bad++;
        $display("[TB] FAIL x4_key got=%h want=%h", descrDataOut, known[i]);
      end
    end
  endtask

  task automatic test_skp();
    logic [31:0] words[3] = '{32'h0000_00BC, 32'h0000_1C00, 32'h0000_0000};
    logic [3:0]  ks[3]    = '{4'b0001, 4'b0010, 4'b0000};
    logic [15:0] known[3] = '{16'hFFBC, 16'h1C17, 16'h14C0};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 6'd16, words[i], ks[i], 4'b0011);
      e = sb_q.pop_front();
      total++;
      if ({descrDataOut, descrDataK, descrDataValid} !== {e.data, e.k, e.valid}) begin
        bad++;
        $display("[TB] FAIL skp got=%h/%h/%h want=%h/%h/%h", descrDataOut, descrDataK, descrDataValid, e.data, e.k, e.valid);
      end
      total++;
      if (descrDataOut[15:0] !== known[i]) begin
        bad++;
        $display("[TB] FAIL skp_key got=%h want=%h", descrDataOut[15:0], known[i]);
      end
    end
  endtask

  task automatic test_turnoff();
    logic [7:0] syms[6]  = '{8'hBC, 8'h00, 8'hA5, 8'h5A, 8'h3C, 8'h00};
    logic       offs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] known[6] = '{8'hBC, 8'hFF, 8'hA5, 8'h5A, 8'h3C, 8'hB2};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, offs[i], 6'd8, {24'h0, syms[i]}, (i == 0) ? 4'b0001 : 4'b0000, 4'b0001);
      e = sb_q.pop_front();
      total++;
      if ({descrDataOut, descrDataK, descrDataValid} !== {e.data, e.k, e.valid}) begin
        bad++;
        $display("[TB] FAIL turnoff got=%h/%h/%h want=%h/%h/%h", descrDataOut, descrDataK, descrDataValid, e.data, e.k, e.valid);
      end
      total++;
      if (descrDataOut[7:0] !== known[i]) begin
        bad++;
        $display("[TB] FAIL turnoff_key got=%h want=%h", descrDataOut[7:0], known[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 2, 1'b0, (i == 3) ? 6'd8 : 6'd32, (i == 3) ? 32'h0 : $urandom, 4'b0000, 4'hF);
      e = sb_q.pop_front();
      total++;
      if ({descrDataOut, descrDataK, descrDataValid} !== {e.data, e.k, e.valid}) begin
        bad++;
        $display("[TB] FAIL reset_mid got=%h/%h/%h want=%h/%h/%h", descrDataOut, descrDataK, descrDataValid, e.data, e.k, e.valid);
      end
    end
    total++;
    if (descrDataOut !== 32'h0000_00FF) begin
      bad++;
      $display("[TB] FAIL reset_mid_seed got=%h want=000000FF", descrDataOut);
    end
  endtask

  task automatic test_pipewidth();
    logic [5:0] widths[5] = '{6'd24, 6'd0, 6'd16, 6'd8, 6'd32};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, widths[i], $urandom, 4'b0000, 4'hF);
      e = sb_q.pop_front();
      total++;
      if ({descrDataOut, descrDataK, descrDataValid} !== {e.data, e.k, e.valid}) begin
        bad++;
        $display("[TB] FAIL width got=%h/%h/%h want=%h/%h/%h w=%0d", descrDataOut, descrDataK, descrDataValid, e.data, e.k, e.valid, widths[i]);
      end
      if (i < 2) begin
        total++;
        if ({descrDataOut, descrDataValid} !== 36'h0) begin
          bad++;
          $display("[TB] FAIL width_idle got=%h/%h want=0/0", descrDataOut, descrDataValid);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  wsel[4] = '{6'd8, 6'd16, 6'd32, 6'd0};
    logic [31:0] d;
    logic [3:0]  k;
    exp_t        e;
    for (int n = 0; n < 80; n++) begin
      d = $urandom;
      k = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 7))
          0: begin d[i*8 +: 8] = 8'hBC; k[i] = 1'b1; end
          1: begin d[i*8 +: 8] = 8'h1C; k[i] = 1'b1; end
          2: k[i] = 1'b1;
          default: ;
        endcase
      end
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, wsel[$urandom_range(0, 3)],
                    d, k, 4'($urandom_range(0, 15)));
      e = sb_q.pop_front();
      total++;
      if ({descrDataOut, descrDataK, descrDataValid} !== {e.data, e.k, e.valid}) begin
        bad++;
        $display("[TB] FAIL b2b got=%h/%h/%h want=%h/%h/%h", descrDataOut, descrDataK, descrDataValid, e.data, e.k, e.valid);
      end
`ifdef RX_DESCRAMBLER_LOCK_EN
      total++;
      if (locked !== e.locked) begin
        bad++;
        $display("[TB] FAIL b2b_locked got=%b want=%b", locked, e.locked);
      end
`endif
    end
  endtask

  initial begin
    reset       = 1'b1;
    turnOff     = 1'b0;
    PIPEWIDTH   = 6'd8;
    rxData      = 32'h0;
    rxDataK     = 4'h0;
    rxDataValid = 4'h0;
    m_lfsr      = 16'hFFFF;
    m_locked    = 1'b0;
    test_reset();
`ifdef RX_DESCRAMBLER_LOCK_EN
    test_lock();
`endif
    test_single_lane();
    test_quad_lane();
    test_skp();
    test_turnoff();
    test_reset_mid();
    test_pipewidth();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
